key_press_conditioner: RTL

- Front-end stage for the board push-button. Sits directly upstream of the press-duration and LED-toggle logic.
- Synchronises the raw active-low `KEY1` pin into the `FPGA_CLK` domain and debounces it.
- Classifies each press as short or long and emits clean one-cycle event pulses plus a debounced level for downstream consumers.

---
 rtl/key_press_conditioner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/key_press_conditioner.sv
// key_press_conditioner
// Front end for the board push-button. Brings the raw active-low KEY1 pin
// into the FPGA_CLK domain, debounces it, and classifies each accepted press
// as short or long. Downstream logic gets a clean debounced level plus
// one-cycle event pulses. Every output comes straight from a flop.
module key_press_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic FPGA_CLK,
  input  logic RST_N,
  input  logic KEY1,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);

  // Debounce counting restarts at 1 because the edge that leaves the stable
  // state already counts as the first differing sample.
  localparam logic [DEB_W-1:0]  DEB_FIRST = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    LONG_HELD   = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  // Synchroniser chain. Resets to all ones so a reset looks like "released".
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;

  state_t                 state_q,       state_d;
  logic [DEB_W-1:0]       deb_cnt_q,     deb_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q,    hold_cnt_d;
  logic                   long_seen_q,   long_seen_d;

  logic                   key_level_q,   key_level_d;
  logic                   press_q,       press_d;
  logic                   release_q,     release_d;
  logic                   short_q,       short_d;
  logic                   long_q,        long_d;

  // Shift the raw pin through the synchroniser flops.
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], KEY1};
    end
  end

  assign key_s = sync_q[SYNC_STAGES-1];

  // Register FSM state, counters and the registered outputs.
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_seen_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_seen_q <= long_seen_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      short_q     <= short_d;
      long_q      <= long_d;
    end
  end

  // Next-state, counter and pulse decode. Pulses default low so each one
  // lasts a single cycle; the debounced level holds unless an edge is accepted.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_seen_d = long_seen_q;
    key_level_d = key_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d   = DEB_PRESS;
          deb_cnt_d = DEB_FIRST;
        end
      end

      DEB_PRESS: begin
        if (key_s) begin
          // Bounce: drop back silently.
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = PRESSED;
          hold_cnt_d  = '0;
          long_seen_d = 1'b0;
          key_level_d = 1'b1;
          press_d     = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        // A possible release wins over the long threshold on the same edge;
        // the hold count stays frozen while the release is being debounced.
        if (key_s) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = DEB_FIRST;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = LONG_HELD;
          long_d      = 1'b1;
          long_seen_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      LONG_HELD: begin
        if (key_s) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = DEB_FIRST;
        end
      end

      DEB_RELEASE: begin
        if (!key_s) begin
          // Release glitch: resume where we were without advancing the hold count.
          state_d = long_seen_q ? LONG_HELD : PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          key_level_d = 1'b0;
          release_d   = 1'b1;
          short_d     = !long_seen_q;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;

endmodule
